// File: rtl/field_fifo_ctrl.sv
// field_fifo_ctrl - write/read scheduler for the FAST decoder shared field buffer.
//
// Packs up to NUM_DEC valid decoder lanes per cycle, gap-free and in lane order,
// into a circular register buffer of DEPTH slots. Drains oldest-first through one
// valid/ready port with first-word fall-through from registers.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   in_valid         per-lane field valid (NUM_DEC)
//   in_field         lane i at [i*FW +: FW]
//   in_ready         room for a full NUM_DEC-lane write (from registered count only)
//   out_valid        head field present
//   out_field        head (oldest) field
//   out_ready        consumer takes head
//   flush            synchronous discard of all buffered fields (beats push/pop)
//   occupancy        fields currently buffered

// Per-lane target slot: base + prefix offset, reduced once mod DEPTH.
// base < DEPTH and off <= NUM_DEC <= DEPTH, so a single subtract is enough.
module field_fifo_lane #(
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int LW    = 3
) (
  input  logic [PW-1:0] base,
  input  logic [LW-1:0] off,
  output logic [PW-1:0] slot
);
  int sum;
  always_comb begin
    sum = int'(base) + int'(off);
    if (sum >= DEPTH) sum = sum - DEPTH;
    slot = PW'(sum);
  end
endmodule

module field_fifo_ctrl #(
  parameter int NUM_DEC      = 4,
  parameter int BEAT_WIDTH   = 64,
  parameter int MAX_MSG_SIZE = 10,
  parameter int MSGID_SIZE   = 21,
  parameter int DEPTH        = 8,
  localparam int FW = MSGID_SIZE + $clog2(MAX_MSG_SIZE) + BEAT_WIDTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_DEC-1:0]    in_valid,
  input  logic [NUM_DEC*FW-1:0] in_field,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [FW-1:0]         out_field,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [CW-1:0]         occupancy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(NUM_DEC + 1);

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CW-1:0] count, count_next;
  logic [NUM_DEC-1:0][LW-1:0] off;
  logic [NUM_DEC-1:0][PW-1:0] slot;
  logic [LW-1:0] n_push;
  logic push, pop;
  int   cnt_i;

  // Prefix popcount: lane i lands at wr_ptr + (number of valid lanes below i).
  always_comb begin
    n_push = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      off[i] = n_push;
      n_push = n_push + LW'(in_valid[i]);
    end
  end

  for (genvar g = 0; g < NUM_DEC; g++) begin : g_lane
    field_fifo_lane #(.DEPTH(DEPTH), .PW(PW), .LW(LW)) u_lane (
      .base (wr_ptr),
      .off  (off[g]),
      .slot (slot[g])
    );
  end

  // in_ready only looks at registered count: no out_ready -> in_ready path.
  assign in_ready  = (int'(count) + NUM_DEC) <= DEPTH;
  assign out_valid = (count != '0);
  assign out_field = mem[rd_ptr];
  assign occupancy = count;

  assign push = in_ready & (|in_valid);
  assign pop  = out_valid & out_ready;

  always_comb begin
    int w, r;
    w = int'(wr_ptr) + int'(n_push);
    if (w >= DEPTH) w = w - DEPTH;
    r = int'(rd_ptr) + 1;
    if (r >= DEPTH) r = r - DEPTH;
    cnt_i = int'(count) + (push ? int'(n_push) : 0) - (pop ? 1 : 0);
    wr_next    = PW'(w);
    rd_next    = PW'(r);
    count_next = CW'(cnt_i);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // mem keeps stale data; it is unreachable once count is 0
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < NUM_DEC; i++)
          if (in_valid[i]) mem[slot[i]] <= in_field[i*FW +: FW];
        wr_ptr <= wr_next;
      end
      if (pop) rd_ptr <= rd_next;
      count <= count_next;
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      assert (int'(count) <= DEPTH);
      if (!flush) begin
        assert (cnt_i >= 0);
        assert (cnt_i <= DEPTH);
      end
    end
  end
endmodule

// File: tb/tb_field_fifo_ctrl.sv
module tb_field_fifo_ctrl;
  localparam int FW = 89;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic [3:0]      vld8 = '0;
  logic [4*FW-1:0] fld8 = '0;
  logic            ordy8 = 1'b0, flush8 = 1'b0;
  logic            irdy8, ovld8;
  logic [FW-1:0]   ofld8;
  logic [3:0]      occ8;

  // DEPTH=6 instance for wrap checks
  logic [3:0]      vld6 = '0;
  logic [4*FW-1:0] fld6 = '0;
  logic            ordy6 = 1'b0, flush6 = 1'b0;
  logic            irdy6, ovld6;
  logic [FW-1:0]   ofld6;
  logic [2:0]      occ6;

  int total = 0;
  int bad = 0;

  field_fifo_ctrl #(.DEPTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(vld8), .in_field(fld8), .in_ready(irdy8),
    .out_valid(ovld8), .out_field(ofld8), .out_ready(ordy8), .flush(flush8),
    .occupancy(occ8)
  );

  field_fifo_ctrl #(.DEPTH(6)) dut6 (
    .clk(clk), .rstn(rstn), .in_valid(vld6), .in_field(fld6), .in_ready(irdy6),
    .out_valid(ovld6), .out_field(ofld6), .out_ready(ordy6), .flush(flush6),
    .occupancy(occ6)
  );

  function automatic logic [FW-1:0] fv(int v);
    return {25'(v * 7 + 3), 64'hC0DE_0000_0000_0000 | 64'(v)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    total++; if (irdy8 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", irdy8); end
    total++; if (ovld8 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", ovld8); end
    total++; if (ofld8 !== '0) begin bad++; $display("FAIL rst_out_field got=%h exp=0", ofld8); end
    total++; if (occ8 !== 4'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occ8); end
    total++; if (occ6 !== 3'd0 || irdy6 !== 1'b1) begin bad++; $display("FAIL rst_dut6 occ=%0d rdy=%b exp 0/1", occ6, irdy6); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_full_push();
    vld8 = 4'b1111;
    fld8 = {fv(13), fv(12), fv(11), fv(10)};
    step();
    vld8 = '0;
    total++; if (occ8 !== 4'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occ8); end
    total++; if (ovld8 !== 1'b1 || ofld8 !== fv(10)) begin bad++; $display("FAIL full_head got=%h vld=%b exp=%h", ofld8, ovld8, fv(10)); end
    ordy8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (ofld8 !== fv(10 + k)) begin bad++; $display("FAIL full_pop%0d got=%h exp=%h", k, ofld8, fv(10 + k)); end
      step();
    end
    ordy8 = 1'b0;
    total++; if (occ8 !== 4'd0 || ovld8 !== 1'b0) begin bad++; $display("FAIL full_drained occ=%0d vld=%b exp 0/0", occ8, ovld8); end
  endtask

  task automatic test_sparse();
    vld8 = 4'b1010;
    fld8 = {fv(21), fv(99), fv(20), fv(98)};  // lane1=X(20), lane3=Y(21), others junk
    step();
    total++; if (occ8 !== 4'd2) begin bad++; $display("FAIL sparse_occ got=%0d exp=2", occ8); end
    total++; if (ofld8 !== fv(20)) begin bad++; $display("FAIL sparse_head got=%h exp=%h", ofld8, fv(20)); end
    vld8 = 4'b0001;
    fld8 = {fv(97), fv(96), fv(95), fv(22)};
    step();
    vld8 = '0;
    total++; if (occ8 !== 4'd3) begin bad++; $display("FAIL sparse_occ3 got=%0d exp=3", occ8); end
    ordy8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (ofld8 !== fv(20 + k)) begin bad++; $display("FAIL sparse_pop%0d got=%h exp=%h", k, ofld8, fv(20 + k)); end
      step();
    end
    ordy8 = 1'b0;
    total++; if (occ8 !== 4'd0) begin bad++; $display("FAIL sparse_drained got=%0d exp=0", occ8); end
  endtask

  task automatic test_backpressure();
    vld8 = 4'b1111;
    fld8 = {fv(33), fv(32), fv(31), fv(30)};
    step();
    total++; if (occ8 !== 4'd4 || irdy8 !== 1'b1) begin bad++; $display("FAIL bp_half occ=%0d rdy=%b exp 4/1", occ8, irdy8); end
    fld8 = {fv(37), fv(36), fv(35), fv(34)};
    step();
    total++; if (occ8 !== 4'd8 || irdy8 !== 1'b0) begin bad++; $display("FAIL bp_full occ=%0d rdy=%b exp 8/0", occ8, irdy8); end
    // decoders hold new data while blocked
    fld8 = {fv(53), fv(52), fv(51), fv(50)};
    step();
    total++; if (occ8 !== 4'd8) begin bad++; $display("FAIL bp_hold occ=%0d exp=8", occ8); end
    ordy8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (ofld8 !== fv(30 + k)) begin bad++; $display("FAIL bp_pop%0d got=%h exp=%h", k, ofld8, fv(30 + k)); end
      step();
      if (k < 3) begin
        total++; if (irdy8 !== 1'b0 || occ8 !== 4'(7 - k)) begin bad++; $display("FAIL bp_still_full%0d rdy=%b occ=%0d exp 0/%0d", k, irdy8, occ8, 7 - k); end
      end
    end
    vld8 = '0;
    total++; if (irdy8 !== 1'b1 || occ8 !== 4'd4) begin bad++; $display("FAIL bp_release rdy=%b occ=%0d exp 1/4", irdy8, occ8); end
    for (int k = 0; k < 4; k++) begin
      total++; if (ofld8 !== fv(34 + k)) begin bad++; $display("FAIL bp_tail%0d got=%h exp=%h", k, ofld8, fv(34 + k)); end
      step();
    end
    ordy8 = 1'b0;
    total++; if (occ8 !== 4'd0) begin bad++; $display("FAIL bp_drained got=%0d exp=0", occ8); end
  endtask

  task automatic test_wrap();
    int g = 0, rcv = 0, max_occ = 0, cyc = 0;
    logic pushing;
    ordy6 = 1'b1;
    while (rcv < 20 && cyc < 200) begin
      vld6 = (g < 10) ? 4'b0011 : 4'b0000;
      fld6 = {fv(999), fv(998), fv(100 + 2 * g + 1), fv(100 + 2 * g)};
      pushing = irdy6 && (g < 10);
      if (ovld6) begin
        total++; if (ofld6 !== fv(100 + rcv)) begin bad++; $display("FAIL wrap_out%0d got=%h exp=%h", rcv, ofld6, fv(100 + rcv)); end
        rcv++;
      end
      step();
      if (pushing) g++;
      if (int'(occ6) > max_occ) max_occ = int'(occ6);
      cyc++;
    end
    vld6 = '0;
    ordy6 = 1'b0;
    total++; if (rcv != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", rcv); end
    total++; if (max_occ > 6) begin bad++; $display("FAIL wrap_max_occ got=%0d exp<=6", max_occ); end
    total++; if (occ6 !== 3'd0) begin bad++; $display("FAIL wrap_drained got=%0d exp=0", occ6); end
  endtask

  task automatic test_flush();
    vld8 = 4'b1111;
    fld8 = {fv(43), fv(42), fv(41), fv(40)};
    step();
    vld8 = 4'b0001;
    fld8 = {fv(0), fv(0), fv(0), fv(44)};
    step();
    total++; if (occ8 !== 4'd5) begin bad++; $display("FAIL flush_pre occ=%0d exp=5", occ8); end
    flush8 = 1'b1;
    ordy8 = 1'b1;
    vld8 = 4'b1111;
    fld8 = {fv(63), fv(62), fv(61), fv(60)};
    step();
    flush8 = 1'b0;
    ordy8 = 1'b0;
    vld8 = '0;
    total++; if (occ8 !== 4'd0 || ovld8 !== 1'b0 || irdy8 !== 1'b1) begin bad++; $display("FAIL flush_empty occ=%0d vld=%b rdy=%b exp 0/0/1", occ8, ovld8, irdy8); end
    vld8 = 4'b0001;
    fld8 = {fv(0), fv(0), fv(0), fv(70)};
    step();
    vld8 = '0;
    total++; if (occ8 !== 4'd1 || ofld8 !== fv(70)) begin bad++; $display("FAIL flush_after occ=%0d got=%h exp 1/%h", occ8, ofld8, fv(70)); end
    ordy8 = 1'b1;
    step();
    ordy8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    vld8 = 4'b0111;
    fld8 = {fv(0), fv(82), fv(81), fv(80)};
    step();
    vld8 = '0;
    total++; if (occ8 !== 4'd3) begin bad++; $display("FAIL rmid_pre occ=%0d exp=3", occ8); end
    rstn = 1'b0;
    step();
    total++; if (occ8 !== 4'd0 || ovld8 !== 1'b0 || irdy8 !== 1'b1 || ofld8 !== '0) begin bad++; $display("FAIL rmid_reset occ=%0d vld=%b rdy=%b fld=%h", occ8, ovld8, irdy8, ofld8); end
    rstn = 1'b1;
    vld8 = 4'b0001;
    fld8 = {fv(0), fv(0), fv(0), fv(90)};
    step();
    vld8 = '0;
    total++; if (occ8 !== 4'd1 || ofld8 !== fv(90)) begin bad++; $display("FAIL rmid_new occ=%0d got=%h exp 1/%h", occ8, ofld8, fv(90)); end
    ordy8 = 1'b1;
    step();
    ordy8 = 1'b0;
    total++; if (occ8 !== 4'd0 || ovld8 !== 1'b0) begin bad++; $display("FAIL rmid_drain occ=%0d vld=%b exp 0/0", occ8, ovld8); end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_push();
    test_sparse();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
